ce_scheduler: RTL and testbench
===============================

// Module: ce_scheduler
// PURPOSE
//  Multi-channel clock-enable scheduler driven by one base tick (CE_IN) from the CE generator.
//  Each of NCH channels is configured with a period N (in CE_IN ticks) and a mode.
//  In periodic mode a channel emits a 1-CLK CE_OUT pulse every N ticks; in one-shot mode it
//  emits one pulse, then raises a sticky DONE that the consumer acknowledges.
//  Lets several consumers (display scan, debounce, LED blink, timeouts) share one base tick.
// PARAMETERS
//  NCH  4   number of channels (1..16)
//  PW   17  period/counter width in bits; maximum period 2^PW-1 ticks
//  SW   2   CFG_SEL width, >= clog2(NCH)
// PORTS
//  CLK         in   1        system clock; all logic on posedge CLK
//  RST         in   1        asynchronous, active-high reset
//  CE_IN       in   1        base tick, 1-CLK pulse (e.g. every 100000 CLK)
//  CFG_WE      in   1        config write strobe, 1 CLK
//  CFG_SEL     in   SW       channel index for the write
//  CFG_PERIOD  in   PW       period N in CE_IN ticks; 0 = disable channel
//  CFG_MODE    in   1        0 = periodic, 1 = one-shot
//  CFG_EN      in   1        1 = start/arm channel, 0 = stop channel
//  DONE_ACK    in   NCH      per-channel 1-CLK acknowledge; clears DONE[i]
//  CE_OUT      out  NCH      per-channel enable pulses, registered, 1 CLK wide
//  BUSY        out  NCH      channel i is armed and counting
//  DONE        out  NCH      sticky one-shot expiry flag
// BEHAVIOUR
//  Reset: all periods, counters and modes = 0; every channel IDLE; CE_OUT = BUSY = DONE = 0.
//  Per-channel states: IDLE (not counting), RUN (counting). BUSY[i] = (state == RUN).
//  Config write (CFG_WE=1, CFG_SEL<NCH), applied to channel CFG_SEL at that edge:
//   - period <= CFG_PERIOD; mode <= CFG_MODE; cnt <= CFG_PERIOD; DONE[i] <= 0
//   - state <= RUN if CFG_EN=1 and CFG_PERIOD!=0, else IDLE
//   - a write during RUN restarts the count; no CE_OUT for that channel results from the write
//  CFG_SEL >= NCH: the write is ignored and no channel changes.
//  In RUN, at each edge with CE_IN=1:
//   - cnt > 1: cnt <= cnt-1
//   - cnt == 1 (expiry): CE_OUT[i] = 1 for the next CLK cycle only (1-CLK latency from the CE_IN cycle)
//       periodic: cnt <= period, stay RUN
//       one-shot: state <= IDLE, DONE[i] <= 1
//  The first CE_OUT occurs on the N-th CE_IN after the write; spacing is exactly N ticks.
//  N=1 periodic: CE_OUT follows every CE_IN, delayed 1 CLK.
//  Simultaneous events:
//   - CFG write and CE_IN on the same channel in the same cycle: the write wins and that tick is not
//     counted. Other channels count normally.
//   - expiry and DONE_ACK[i] in the same cycle: the set wins, so DONE[i] = 1.
//   - DONE_ACK while DONE = 0: no effect.
//  IDLE ignores CE_IN. CE_OUT is 0 whenever the state is IDLE, except for the expiry pulse.
//  DONE is never set in periodic mode.
//  Reset mid-operation: returns to the reset state immediately; any pending pulse is dropped.
//  Channels are independent; several CE_OUT bits may assert in the same cycle.
// STRUCTURE
//  Shared package ce_sched_pkg:
//   - MODE_PERIODIC = 1'b0, MODE_ONESHOT = 1'b1
//   - state encoding ST_IDLE / ST_RUN
//   - default PW = 17
//  Sub-module ce_sched_chan:
//   - one channel: period/mode registers, down-counter, state, CE_OUT/DONE flops
//   - instantiated NCH times in a generate loop
//  Top level: decodes CFG_SEL into per-channel write strobes and concatenates the outputs.
// TESTING
//  1 Reset: assert RST mid-run with ch0 busy -> CE_OUT=0, BUSY=0, DONE=0 at once; no pulses after release.
//  2 Periodic: ch0 N=3, mode=0, EN=1; 10 CE_IN -> CE_OUT[0] after ticks 3, 6, 9, each 1 CLK, 1 CLK late;
//    BUSY[0]=1 throughout.
//  3 One-shot: ch1 N=2, mode=1 -> one CE_OUT[1] after tick 2, then BUSY[1]=0 and DONE[1]=1 held;
//    DONE_ACK[1] -> DONE[1]=0; further ticks give no pulse.
//  4 Collisions:
//    - write ch2 N=4 in the same cycle as CE_IN -> first pulse after 4 further ticks
//    - ACK in the same cycle as ch1 expiry -> DONE[1] stays 1
//  5 Edges:
//    - N=0 write -> ch idle, BUSY=0
//    - N=1 -> pulse per tick
//    - N=131071 -> single pulse after 131071 ticks
//    - CFG_SEL=5 with NCH=4 -> no change
//  6 Concurrency: ch0 N=2, ch3 N=4 periodic -> both CE_OUT bits high together every 4th tick;
//    restart ch0 mid-count -> count restarts from the write.

Source files
------------

// File: rtl/ce_sched_pkg.sv
// Shared definitions for the clock-enable scheduler: channel modes, channel state
// encoding and the default period width.
package ce_sched_pkg;

  localparam int PW_DEFAULT = 17;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } chan_state_t;

endpackage

// File: rtl/ce_sched_chan.sv
// One scheduler channel: holds period and mode, counts base ticks down while running,
// and emits a registered 1-CLK pulse on expiry (plus a sticky DONE in one-shot mode).
module ce_sched_chan
  import ce_sched_pkg::*;
#(
  parameter int PW = PW_DEFAULT
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ce_in,
  input  logic          cfg_we,
  input  logic [PW-1:0] cfg_period,
  input  logic          cfg_mode,
  input  logic          cfg_en,
  input  logic          done_ack,
  output logic          ce_out,
  output logic          busy,
  output logic          done
);

  chan_state_t   state_q, state_d;
  logic [PW-1:0] period_q, period_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;
  logic          ce_q, ce_d;
  logic          done_q, done_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      period_q <= '0;
      cnt_q    <= '0;
      mode_q   <= MODE_PERIODIC;
      ce_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      ce_q     <= ce_d;
      done_q   <= done_d;
    end
  end

  // A config write overrides any tick in the same cycle; an expiry's DONE set
  // is applied after the acknowledge so the set wins a same-cycle collision.
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    ce_d     = 1'b0;
    done_d   = done_q;

    if (done_ack) done_d = 1'b0;

    if (cfg_we) begin
      period_d = cfg_period;
      mode_d   = cfg_mode;
      cnt_d    = cfg_period;
      done_d   = 1'b0;
      state_d  = (cfg_en && (cfg_period != '0)) ? ST_RUN : ST_IDLE;
    end else if ((state_q == ST_RUN) && ce_in) begin
      if (cnt_q > PW'(1)) begin
        cnt_d = cnt_q - PW'(1);
      end else begin
        ce_d = 1'b1;
        if (mode_q == MODE_ONESHOT) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = period_q;
        end
      end
    end
  end

  assign ce_out = ce_q;
  assign busy   = (state_q == ST_RUN);
  assign done   = done_q;

endmodule

// File: rtl/ce_scheduler.sv
// Multi-channel clock-enable scheduler: fans one base tick out to NCH independently
// configured channels, each periodic or one-shot.
module ce_scheduler
  import ce_sched_pkg::*;
#(
  parameter int NCH = 4,
  parameter int PW  = PW_DEFAULT,
  parameter int SW  = 2
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           CE_IN,
  input  logic           CFG_WE,
  input  logic [SW-1:0]  CFG_SEL,
  input  logic [PW-1:0]  CFG_PERIOD,
  input  logic           CFG_MODE,
  input  logic           CFG_EN,
  input  logic [NCH-1:0] DONE_ACK,
  output logic [NCH-1:0] CE_OUT,
  output logic [NCH-1:0] BUSY,
  output logic [NCH-1:0] DONE
);

  // Selectors at or beyond NCH match no channel, so such writes are dropped.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    logic we_ch;

    assign we_ch = CFG_WE && (int'(CFG_SEL) == gi);

    ce_sched_chan #(
      .PW(PW)
    ) u_chan (
      .CLK       (CLK),
      .RST       (RST),
      .ce_in     (CE_IN),
      .cfg_we    (we_ch),
      .cfg_period(CFG_PERIOD),
      .cfg_mode  (CFG_MODE),
      .cfg_en    (CFG_EN),
      .done_ack  (DONE_ACK[gi]),
      .ce_out    (CE_OUT[gi]),
      .busy      (BUSY[gi]),
      .done      (DONE[gi])
    );
  end

endmodule

// File: tb/tb_ce_scheduler.sv
// Scoreboard bench for ce_scheduler: a tick-counting reference model predicts each
// cycle's outputs, a separate monitor compares them after every rising edge.
module tb_ce_scheduler;

  localparam int NCH = 4;
  localparam int PW  = 17;
  localparam int SW  = 3;

  logic           CLK = 1'b0;
  logic           RST;
  logic           CE_IN;
  logic           CFG_WE;
  logic [SW-1:0]  CFG_SEL;
  logic [PW-1:0]  CFG_PERIOD;
  logic           CFG_MODE;
  logic           CFG_EN;
  logic [NCH-1:0] DONE_ACK;
  logic [NCH-1:0] CE_OUT;
  logic [NCH-1:0] BUSY;
  logic [NCH-1:0] DONE;

  ce_scheduler #(.NCH(NCH), .PW(PW), .SW(SW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .CE_IN     (CE_IN),
    .CFG_WE    (CFG_WE),
    .CFG_SEL   (CFG_SEL),
    .CFG_PERIOD(CFG_PERIOD),
    .CFG_MODE  (CFG_MODE),
    .CFG_EN    (CFG_EN),
    .DONE_ACK  (DONE_ACK),
    .CE_OUT    (CE_OUT),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [NCH-1:0] ce;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] done;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  // Model: a channel pulses when the number of ticks it has seen since its last
  // write is a whole multiple of its period.
  bit          m_act  [NCH];
  int unsigned m_per  [NCH];
  bit          m_mode [NCH];
  int unsigned m_since[NCH];
  bit          m_done [NCH];

  task automatic modelReset();
    for (int c = 0; c < NCH; c++) begin
      m_act[c] = 0; m_per[c] = 0; m_mode[c] = 0; m_since[c] = 0; m_done[c] = 0;
    end
  endtask

  task automatic modelStep(input bit ce, input bit we, input int sel, input int period,
                           input bit md, input bit en, input logic [NCH-1:0] ack,
                           output exp_t e);
    e = '0;
    for (int c = 0; c < NCH; c++) begin
      if (we && sel == c) begin
        m_per[c] = period; m_mode[c] = md; m_since[c] = 0; m_done[c] = 0;
        m_act[c] = en && (period != 0);
      end else begin
        if (ack[c]) m_done[c] = 0;
        if (m_act[c] && ce) begin
          m_since[c]++;
          if (m_since[c] % m_per[c] == 0) begin
            e.ce[c] = 1'b1;
            if (m_mode[c]) begin
              m_act[c]  = 0;
              m_done[c] = 1;
            end
          end
        end
      end
      e.busy[c] = m_act[c];
      e.done[c] = m_done[c];
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d got %h want %h", name, cycle, got, want);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit ce, input bit we, input int sel,
                               input int period, input bit md, input bit en,
                               input logic [NCH-1:0] ack);
    exp_t e;
    @(negedge CLK);
    RST        = rst;
    CE_IN      = ce;
    CFG_WE     = we;
    CFG_SEL    = SW'(sel);
    CFG_PERIOD = PW'(period);
    CFG_MODE   = md;
    CFG_EN     = en;
    DONE_ACK   = ack;
    if (rst) begin
      modelReset();
      e = '0;
    end else begin
      modelStep(ce, we, sel, period, md, en, ack, e);
    end
    expq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, '0);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(0, 1, 0, 0, 0, 0, 0, '0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, '0);
    end
  endtask

  task automatic cfg(input int sel, input int period, input bit md, input bit en, input bit ce);
    applyStimulus(0, ce, 1, sel, period, md, en, '0);
  endtask

  task automatic ack(input logic [NCH-1:0] a, input bit ce);
    applyStimulus(0, ce, 0, 0, 0, 0, 0, a);
  endtask

  task automatic asyncReset();
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    checkOutput("async_rst_ce_out", 32'(CE_OUT), 32'd0);
    checkOutput("async_rst_busy",   32'(BUSY),   32'd0);
    checkOutput("async_rst_done",   32'(DONE),   32'd0);
    modelReset();
  endtask

  task automatic stopAll();
    for (int c = 0; c < NCH; c++) cfg(c, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        checkOutput("ce_out", 32'(CE_OUT), 32'(e.ce));
        checkOutput("busy",   32'(BUSY),   32'(e.busy));
        checkOutput("done",   32'(DONE),   32'(e.done));
        cycle++;
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    errors++;
    $display("[TB] FAIL timeout expected_pending %0d required 0", expq.size());
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : driver
    logic [NCH-1:0] a;
    bit rce, rwe, rmd, ren;
    RST = 1'b1; CE_IN = 0; CFG_WE = 0; CFG_SEL = '0; CFG_PERIOD = '0;
    CFG_MODE = 0; CFG_EN = 0; DONE_ACK = '0;
    modelReset();
    #12;
    checkOutput("por_ce_out", 32'(CE_OUT), 32'd0);
    checkOutput("por_busy",   32'(BUSY),   32'd0);
    checkOutput("por_done",   32'(DONE),   32'd0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, '0);
    idle(2);

    $display("[TB] periodic ch0 N=3");
    cfg(0, 3, 0, 1, 0);
    tick(10);

    $display("[TB] async reset with ch0 busy");
    asyncReset();
    applyStimulus(1, 1, 0, 0, 0, 0, 0, '0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, '0);
    tick(6);

    $display("[TB] one-shot ch1 N=2");
    cfg(1, 2, 1, 1, 0);
    tick(3);
    ack(4'b0010, 0);
    tick(3);

    $display("[TB] collisions");
    cfg(2, 4, 0, 1, 1);
    tick(9);
    cfg(1, 2, 1, 1, 0);
    tick(1);
    ack(4'b0010, 1);
    idle(2);
    ack(4'b0010, 0);
    ack(4'b0010, 0);

    $display("[TB] edges");
    cfg(2, 0, 0, 1, 0);
    tick(2);
    cfg(3, 1, 0, 1, 0);
    tick(4);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, '0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, '0);
    cfg(5, 7, 1, 1, 0);
    tick(3);
    cfg(3, 5, 0, 0, 0);
    tick(2);

    $display("[TB] concurrency");
    stopAll();
    cfg(0, 2, 0, 1, 0);
    cfg(3, 4, 0, 1, 0);
    tick(9);
    cfg(0, 2, 0, 1, 0);
    tick(6);

    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++) begin
      rce = ($urandom_range(0, 2) == 0);
      rwe = ($urandom_range(0, 15) == 0);
      rmd = ($urandom_range(0, 1) == 1);
      ren = ($urandom_range(0, 7) != 0);
      for (int b = 0; b < NCH; b++) a[b] = ($urandom_range(0, 7) == 0);
      applyStimulus(0, rce, rwe, int'($urandom_range(0, 7)), int'($urandom_range(0, 6)),
                    rmd, ren, a);
    end

    $display("[TB] maximum period window");
    stopAll();
    cfg(2, 131071, 0, 1, 0);
    for (int i = 0; i < 20000; i++) applyStimulus(0, 1, 0, 0, 0, 0, 0, '0);
    idle(2);

    @(posedge CLK);
    #3;
    checkOutput("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
